// File: rtl/divisor_seq_if.sv
// divisor_seq_if -- start/done handshake and operand/result bundle for the
// sequential signed divider.
//   start      request from the master, sampled only while the divider is idle
//   S          signed dividend, 2*TAM bits
//   B          signed divisor, TAM bits
//   Q, R       signed quotient / remainder, TAM bits each
//   busy       divider is working on an accepted request
//   done       one-cycle pulse when Q, R, ovf and div0 become valid
//   ovf, div0  quotient overflow / divide-by-zero flags
// master: the requester (testbench or surrounding logic); slave: the divider.
`ifndef TAM
`define TAM 8
`endif

interface divisor_seq_if #(parameter int TAM = `TAM) ();
  logic                    start;
  logic signed [2*TAM-1:0] S;
  logic signed [TAM-1:0]   B;
  logic signed [TAM-1:0]   Q;
  logic signed [TAM-1:0]   R;
  logic                    busy;
  logic                    done;
  logic                    ovf;
  logic                    div0;

  modport master (output start, S, B,
                  input  Q, R, busy, done, ovf, div0);
  modport slave  (input  start, S, B,
                  output Q, R, busy, done, ovf, div0);
endinterface

// File: rtl/divisor_seq.sv
// divisor_seq -- radix-2 restoring signed divider working on magnitudes.
// Divides a 2*TAM-bit signed dividend by a TAM-bit signed divisor, producing
// a TAM-bit quotient truncated toward zero and a remainder carrying the sign
// of the dividend.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    divisor_seq_if slave: start/S/B in, Q/R/busy/done/ovf/div0 out
// A request takes 2*TAM+2 edges from acceptance to done; a zero divisor
// skips the iterations and completes in 2 edges.
`ifndef TAM
`define TAM 8
`endif

module divisor_seq #(
  parameter int TAM = `TAM
) (
  input  logic         clk,
  input  logic         rst_n,
  divisor_seq_if.slave bus
);

  localparam int CW = $clog2(2 * TAM);
  localparam logic [2*TAM-1:0] LIM_POS = (2*TAM)'((1 << (TAM - 1)) - 1);
  localparam logic [2*TAM-1:0] LIM_NEG = (2*TAM)'(1 << (TAM - 1));

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t             state, state_next;
  logic [2*TAM-1:0]   dvd;
  logic [2*TAM-1:0]   quo;
  logic [TAM:0]       rem;
  logic [TAM-1:0]     bmag;
  logic [TAM-1:0]     s_low;
  logic [CW-1:0]      cnt;
  logic               sign_s, sign_b, zero_path;

  logic [TAM-1:0]     q_reg, r_reg;
  logic               done_reg, ovf_reg, div0_reg;

  logic [2*TAM-1:0]   s_mag;
  logic [TAM-1:0]     b_mag;
  logic [TAM:0]       rem_shift;
  logic               ge;
  logic               q_neg;
  logic [TAM-1:0]     q_val, r_val;
  logic               ovf_val;

  // Magnitudes are taken as unsigned so the most negative operands still fit.
  // The partial remainder stays below |B|, so one extra bit holds the shift.
  always_comb begin
    state_next = state;
    s_mag      = bus.S[2*TAM-1] ? ((2*TAM)'(0) - bus.S) : bus.S;
    b_mag      = bus.B[TAM-1]   ? (TAM'(0) - bus.B)     : bus.B;
    rem_shift  = {rem[TAM-1:0], dvd[2*TAM-1]};
    ge         = (rem_shift >= {1'b0, bmag});
    q_neg      = sign_s ^ sign_b;
    q_val      = q_neg ? (TAM'(0) - quo[TAM-1:0]) : quo[TAM-1:0];
    r_val      = sign_s ? (TAM'(0) - rem[TAM-1:0]) : rem[TAM-1:0];
    ovf_val    = q_neg ? (quo > LIM_NEG) : (quo > LIM_POS);
    case (state)
      IDLE: if (bus.start) state_next = (bus.B == '0) ? SIGN : CALC;
      CALC: if (cnt == CW'(2 * TAM - 1)) state_next = SIGN;
      SIGN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus datapath. Operands are frozen at acceptance, so the
  // inputs are ignored for the rest of the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
      bmag      <= '0;
      s_low     <= '0;
      cnt       <= '0;
      sign_s    <= 1'b0;
      sign_b    <= 1'b0;
      zero_path <= 1'b0;
      q_reg     <= '0;
      r_reg     <= '0;
      done_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      div0_reg  <= 1'b0;
    end else begin
      state    <= state_next;
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd       <= s_mag;
            bmag      <= b_mag;
            s_low     <= bus.S[TAM-1:0];
            sign_s    <= bus.S[2*TAM-1];
            sign_b    <= bus.B[TAM-1];
            zero_path <= (bus.B == '0);
            rem       <= '0;
            quo       <= '0;
            cnt       <= '0;
          end
        end
        CALC: begin
          rem <= ge ? (rem_shift - {1'b0, bmag}) : rem_shift;
          quo <= {quo[2*TAM-2:0], ge};
          dvd <= {dvd[2*TAM-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
        SIGN: begin
          done_reg <= 1'b1;
          if (zero_path) begin
            q_reg    <= '0;
            r_reg    <= s_low;
            ovf_reg  <= 1'b0;
            div0_reg <= 1'b1;
          end else begin
            q_reg    <= q_val;
            r_reg    <= r_val;
            ovf_reg  <= ovf_val;
            div0_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.busy = (state != IDLE);
  assign bus.done = done_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.div0 = div0_reg;

endmodule
